// File: rtl/sbus_mem_responder.sv
// sbus_mem_responder: memory-controller end of the SBUS quadword read/write protocol.
// It acknowledges one START request and then moves the requested words of the quad,
// giving one DATA_VALID strobe per word. The backing store is a DEPTH x 36-bit array.
// Ports:
//   clk, CROBAR (sync active-high reset);
//   START, ADR, ADR_PAR, RD_RQ, WR_RQ, RQ, DATA_IN (request and write data from the MBOX);
//   ACKN, DATA_VALID, DATA_OUT, ERR, BUSY (registered responses).
module sbus_mem_responder #(
  parameter int DEPTH        = 16384,
  parameter int ACK_DELAY    = 2,
  parameter int ACCESS_DELAY = 3
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        START,
  input  logic [21:0] ADR,
  input  logic        ADR_PAR,
  input  logic        RD_RQ,
  input  logic        WR_RQ,
  input  logic [3:0]  RQ,
  input  logic [35:0] DATA_IN,
  output logic        ACKN,
  output logic        DATA_VALID,
  output logic [35:0] DATA_OUT,
  output logic        ERR,
  output logic        BUSY
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACKWAIT, ACCESS, STROBE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [19:0] base;
  logic [1:0]  ptr;      // rotating search origin for the next requested word
  logic [3:0]  pend;     // requested words not yet transferred
  logic        is_wr;

  logic [35:0] mem [DEPTH];

  // Request qualification
  logic par_ok, dir_ok, in_range;
  assign par_ok   = ^{ADR, ADR_PAR};           // odd parity: total ones across ADR and ADR_PAR is odd
  assign dir_ok   = RD_RQ ^ WR_RQ;
  assign in_range = {10'd0, ADR} < DEPTH_U;

  // The current word is the first pending index at or after ptr, wrapping mod 4.
  logic [1:0] cur_idx;
  always_comb begin
    logic found;
    cur_idx = ptr;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && pend[ptr + 2'(k)]) begin
        cur_idx = ptr + 2'(k);
        found   = 1'b1;
      end
    end
  end

  logic [21:0] word_addr;
  logic        addr_ok;
  logic        remaining;
  logic [35:0] rd_word;
  logic [3:0]  cur_bit;

  assign word_addr = {base, cur_idx};
  assign addr_ok   = {10'd0, word_addr} < DEPTH_U;
  assign cur_bit   = 4'b0001 << cur_idx;
  assign remaining = |(pend & ~cur_bit);
  assign rd_word   = addr_ok ? mem[word_addr[AW-1:0]] : 36'd0;

  // Word store: no reset, so contents survive CROBAR. The write strobe is suppressed
  // in a reset cycle, which lets an abort keep only the words already strobed.
  always_ff @(posedge clk) begin
    if (!CROBAR && state == STROBE && is_wr && addr_ok) begin
      mem[word_addr[AW-1:0]] <= DATA_IN;
    end
  end

  // Protocol FSM; every output is registered, and the pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      base       <= 20'd0;
      ptr        <= 2'd0;
      pend       <= 4'd0;
      is_wr      <= 1'b0;
      ACKN       <= 1'b0;
      DATA_VALID <= 1'b0;
      DATA_OUT   <= 36'd0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      ACKN       <= 1'b0;
      DATA_VALID <= 1'b0;
      DATA_OUT   <= 36'd0;
      ERR        <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (!par_ok || !dir_ok) begin
              ERR <= 1'b1;
            end else if (RQ != 4'd0 && in_range) begin
              // A zero RQ mask or a nonexistent address falls through and is dropped silently.
              base  <= ADR[21:2];
              ptr   <= ADR[1:0];
              pend  <= RQ;
              is_wr <= WR_RQ;
              BUSY  <= 1'b1;
              if (ACK_DELAY <= 1) begin
                ACKN  <= 1'b1;
                state <= ACCESS;
                cnt   <= 3'(ACCESS_DELAY);
              end else begin
                state <= ACKWAIT;
                cnt   <= 3'(ACK_DELAY - 1);
              end
            end
          end
        end
        ACKWAIT: begin
          if (cnt == 3'd1) begin
            ACKN  <= 1'b1;
            state <= ACCESS;
            cnt   <= 3'(ACCESS_DELAY);   // this count includes the ACKN cycle itself
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ACCESS: begin
          if (cnt == 3'd1) begin
            DATA_VALID <= 1'b1;
            state      <= STROBE;
            if (!is_wr) begin
              DATA_OUT <= rd_word;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        STROBE: begin
          pend <= pend & ~cur_bit;
          ptr  <= cur_idx + 2'd1;
          if (remaining) begin
            state <= ACCESS;
            cnt   <= 3'(ACCESS_DELAY - 1);  // the strobe cycle counts toward the spacing
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbus_mem_responder.sv
// tb_sbus_mem_responder: drives random and directed SBUS transfers into sbus_mem_responder.
// Each output is compared, cycle by cycle, with a timeline computed from the protocol rules.
// A sparse associative array holds the words whose contents are known.
module tb_sbus_mem_responder;

  localparam int DEPTH = 16384;
  localparam int AD    = 2;
  localparam int ACD   = 3;

  logic        clk = 1'b0;
  logic        CROBAR, START, ADR_PAR, RD_RQ, WR_RQ;
  logic [21:0] ADR;
  logic [3:0]  RQ;
  logic [35:0] DATA_IN;
  logic        ACKN, DATA_VALID, ERR, BUSY;
  logic [35:0] DATA_OUT;

  sbus_mem_responder #(.DEPTH(DEPTH), .ACK_DELAY(AD), .ACCESS_DELAY(ACD)) dut (
    .clk(clk), .CROBAR(CROBAR), .START(START), .ADR(ADR), .ADR_PAR(ADR_PAR),
    .RD_RQ(RD_RQ), .WR_RQ(WR_RQ), .RQ(RQ), .DATA_IN(DATA_IN),
    .ACKN(ACKN), .DATA_VALID(DATA_VALID), .DATA_OUT(DATA_OUT), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [35:0] ref_mem [int];

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // One transfer. On entry the caller is 1 time unit after a rising edge (cycle 0).
  // On return the bench is in the next cycle, so a chained transfer starts immediately.
  task automatic xfer(input logic [21:0] adr, input bit flip, input bit rd, input bit wr,
                      input logic [3:0] rq, input logic [3:0][35:0] wd,
                      input bit chain, input bit poke, input int abort_after);
    int ord[$];
    int nw, s_last, cutoff, w, k_dv, idx;
    bit bad, acc, live, e_ack, e_dv, e_busy;
    logic [35:0] e_dout;
    int addr;
    bad = flip || (rd == wr);
    acc = !bad && (rq != 4'd0) && (int'(adr) < DEPTH);
    for (int k = 0; k < 4; k++) begin
      idx = (int'(adr[1:0]) + k) % 4;
      if (rq[idx]) ord.push_back(idx);
    end
    nw     = ord.size();
    s_last = AD + nw * ACD;
    cutoff = (acc && abort_after > 0 && abort_after < nw) ? AD + abort_after * ACD + 1 : 1000;
    if (!acc)               w = 6;
    else if (cutoff < 1000) w = cutoff + 3;
    else if (chain)         w = s_last;
    else                    w = s_last + 2;
    if (!acc) poke = 1'b0;

    START   = 1'b1;
    ADR     = adr;
    ADR_PAR = ~(^adr) ^ flip;
    RD_RQ   = rd;
    WR_RQ   = wr;
    RQ      = rq;
    DATA_IN = 36'($urandom());
    for (int n = 1; n <= w; n++) begin
      @(posedge clk);
      #1;
      live   = acc && (n <= cutoff);
      e_ack  = live && (n == AD);
      k_dv   = -1;
      for (int k = 0; k < nw; k++) if (n == AD + (k + 1) * ACD) k_dv = k;
      e_dv   = live && (k_dv >= 0);
      e_busy = live && (n <= s_last);
      chk("ackn", 36'(ACKN), 36'(e_ack));
      chk("data_valid", 36'(DATA_VALID), 36'(e_dv));
      chk("err", 36'(ERR), 36'(bad && n == 1));
      chk("busy", 36'(BUSY), 36'(e_busy));
      if (e_dv) begin
        addr = int'({adr[21:2], 2'b00}) + ord[k_dv];
        if (rd && ref_mem.exists(addr)) begin
          e_dout = ref_mem[addr];
          chk("data_out", DATA_OUT, e_dout);
        end
        if (wr) ref_mem[addr] = wd[k_dv];
      end else begin
        chk("data_out_idle", DATA_OUT, 36'd0);
      end
      // Drive inputs for cycle n; request fields become garbage after acceptance.
      if (n == 1) begin
        START   = 1'b0;
        ADR     = 22'($urandom());
        ADR_PAR = 1'($urandom());
        RD_RQ   = 1'($urandom());
        WR_RQ   = 1'($urandom());
        RQ      = 4'($urandom());
      end
      if (poke && n == 2) START = 1'b1;
      if (poke && n == 3) START = 1'b0;
      CROBAR = (n == cutoff);
      DATA_IN = 36'($urandom());
      for (int k = 0; k < nw; k++) if (n == AD + (k + 1) * ACD) DATA_IN = wd[k];
    end
    START  = 1'b0;
    CROBAR = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0][35:0] wd;
  logic [35:0] va, vb, vc, vd;

  initial begin
    CROBAR = 1'b1; START = 1'b0; ADR = '0; ADR_PAR = 1'b0;
    RD_RQ = 1'b0; WR_RQ = 1'b0; RQ = '0; DATA_IN = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ackn", 36'(ACKN), 36'd0);
    chk("rst_dv", 36'(DATA_VALID), 36'd0);
    chk("rst_dout", DATA_OUT, 36'd0);
    chk("rst_err", 36'(ERR), 36'd0);
    chk("rst_busy", 36'(BUSY), 36'd0);
    CROBAR = 1'b0;
    idle(1);

    // Single word written, then read back.
    wd = '0; wd[0] = 36'o123456701234;
    xfer(22'h100, 0, 0, 1, 4'b0001, wd, 0, 0, 0);
    xfer(22'h100, 0, 1, 0, 4'b0001, wd, 0, 0, 0);

    // Quad preload A..D, then a wrapped read starting at word 2.
    va = 36'hA_0000_000A; vb = 36'hB_1111_000B; vc = 36'hC_2222_000C; vd = 36'hD_3333_000D;
    wd = {vd, vc, vb, va};
    xfer(22'h200, 0, 0, 1, 4'b1111, wd, 0, 0, 0);
    xfer(22'h202, 0, 1, 0, 4'b1111, wd, 0, 0, 0);

    // Sparse write into a preloaded quad; the readback covers all four words.
    wd = {36'h3_0303_0303, 36'h3_0202_0202, 36'h3_0101_0101, 36'h3_0000_0000};
    xfer(22'h300, 0, 0, 1, 4'b1111, wd, 0, 0, 0);
    wd = {36'd0, 36'd0, 36'h5_5555_5555, 36'h7_7777_7777};
    xfer(22'h301, 0, 0, 1, 4'b0101, wd, 0, 0, 0);
    xfer(22'h300, 0, 1, 0, 4'b1111, wd, 0, 0, 0);

    // Rejected requests.
    xfer(22'h100, 1, 1, 0, 4'b0001, wd, 0, 0, 0);
    xfer(22'h100, 0, 1, 1, 4'b0001, wd, 0, 0, 0);
    xfer(22'h100, 0, 0, 0, 4'b0001, wd, 0, 0, 0);
    xfer(22'(DEPTH), 0, 1, 0, 4'b0001, wd, 0, 0, 0);
    xfer(22'h100, 0, 1, 0, 4'b0000, wd, 0, 0, 0);

    // START during a transfer is ignored; a START on the first idle cycle is accepted.
    xfer(22'h200, 0, 1, 0, 4'b1111, wd, 1, 1, 0);
    xfer(22'h202, 0, 1, 0, 4'b0011, wd, 0, 0, 0);

    // Reset between the 2nd and 3rd strobes of a 4-word write.
    wd = {36'h4_0003_0003, 36'h4_0002_0002, 36'h4_0001_0001, 36'h4_0000_0000};
    xfer(22'h400, 0, 0, 1, 4'b1111, wd, 0, 0, 0);
    wd = {36'hF_FFF3_0003, 36'hF_FFF2_0002, 36'hF_FFF1_0001, 36'hF_FFF0_0000};
    xfer(22'h400, 0, 0, 1, 4'b1111, wd, 0, 0, 2);
    xfer(22'h400, 0, 1, 0, 4'b1111, wd, 0, 0, 0);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      logic [21:0] a;
      bit f, r, w;
      int sel;
      a   = (t % 9 == 8) ? 22'(DEPTH + int'($urandom_range(0, 5))) : 22'h500 + 22'($urandom_range(0, 31));
      f   = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 9);
      r   = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : 1'($urandom());
      w   = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : ~r;
      for (int k = 0; k < 4; k++) wd[k] = 36'({$urandom(), $urandom()});
      xfer(a, f, r, w, 4'($urandom()), wd, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sbus_mem_responder.md
Name: sbus_mem_responder

Overview:
- Memory-side responder for the SBUS read/write quadword protocol that the MBOX initiates; behaves as the MB20/MF20 memory-controller end of the bus.
- Accepts one start request, acknowledges it, then transfers the requested words of a quadword, one DATA_VALID strobe per word.
- Backs a simulation-sized 36-bit word store. Used as the MBOX's memory partner in system sims and as the protocol reference for MBOX verification.

Parameters:
- DEPTH, 16384: number of 36-bit words implemented; addresses at or above DEPTH are nonexistent (NXM).
- ACK_DELAY, 2: cycles from the START sample to the ACKN pulse (1..7).
- ACCESS_DELAY, 3: cycles from ACKN, or from the previous DATA_VALID, to the next DATA_VALID (2..7).

Ports:
- clk  in  1  system clock.
- CROBAR  in  1  reset; synchronous, active-high.
- START  in  1  request strobe from the MBOX, sampled only in IDLE.
- ADR  in  22  physical word address (KL10 bits 14:35); ADR[1:0] is the starting word in the quad.
- ADR_PAR  in  1  odd parity over ADR.
- RD_RQ  in  1  read request.
- WR_RQ  in  1  write request.
- RQ  in  4  word-request mask; RQ[i] selects word i of the quad.
- DATA_IN  in  36  write data from the MBOX.
- ACKN  out  1  one-cycle acknowledge pulse.
- DATA_VALID  out  1  one-cycle per-word strobe.
- DATA_OUT  out  36  read data; valid while DATA_VALID=1.
- ERR  out  1  one-cycle pulse on a rejected request.
- BUSY  out  1  high from the accepted START through the last DATA_VALID.

Behaviour:
- Reset: all outputs 0, state IDLE. Memory contents are not cleared. Reset mid-transfer aborts immediately; words already written stay written.
- States: IDLE, ACKWAIT, ACCESS, STROBE.
- Accept rule: in IDLE, START=1 accepts the request when all hold:
  - exactly one of RD_RQ/WR_RQ is set;
  - RQ != 0;
  - ADR parity is correct;
  - ADR < DEPTH.
- On accept: latch the quad base ADR[21:2], start index ADR[1:0], RQ mask and direction; BUSY=1 from the next cycle.
- Rejection:
  - Bad parity, or both/neither of RD_RQ/WR_RQ set: ERR=1 on the next cycle, no ACKN, remain IDLE.
  - RQ=0: ignored silently.
  - NXM: ignored silently (no ACKN, no ERR); the MBOX times out.
- ACKWAIT: counts ACK_DELAY cycles after the START sample, then ACKN=1 for exactly one cycle and the block enters ACCESS.
- Word order:
  - Candidates are the indices start, start+1, start+2, start+3, all mod 4 (wrap-around).
  - An index is transferred only if its latched RQ bit is set.
  - Memory address = {base, index}.
- ACCESS: counts ACCESS_DELAY cycles, then STROBE.
- STROBE, one cycle:
  - DATA_VALID=1.
  - Read: DATA_OUT = mem[addr] in the same cycle.
  - Write: mem[addr] <= DATA_IN, sampled in this cycle.
  - The MBOX presents the next write word starting the cycle after DATA_VALID.
  - Then go to ACCESS if any requested words remain; otherwise go to IDLE, with BUSY=0 on the cycle after the last DATA_VALID.
- DATA_OUT returns to 0 whenever DATA_VALID=0.
- START while BUSY: ignored, never queued. A new request can be accepted starting the first IDLE cycle.
- ACKN and DATA_VALID are never both high. Minimum spacing between strobes is ACCESS_DELAY cycles.
- Inputs other than DATA_IN are ignored after acceptance; changes mid-transfer have no effect.

Test Plan:
- Single read: preload mem[0x100]=0o123456701234; START with ADR=0x100, RD_RQ, RQ=4'b0001 -> ACKN 2 cycles after the START sample, then one DATA_VALID 3 cycles later carrying 0o123456701234, BUSY drops the next cycle, ERR never set.
- Wrapped quad read: preload mem[0x200..0x203]=A,B,C,D; ADR=0x202, RQ=4'b1111 -> four strobes in order C,D,A,B, spaced 3 cycles apart.
- Sparse write: ADR=0x301, WR_RQ, RQ=4'b0101, DATA_IN=X at the first strobe and Y at the second -> mem[0x302]=X, mem[0x300]=Y, mem[0x301] and mem[0x303] unchanged; exactly 2 strobes.
- Rejects:
  - Flipped ADR_PAR -> ERR pulse on the next cycle, no ACKN.
  - RD_RQ=WR_RQ=1 -> ERR.
  - ADR=DEPTH -> no ACKN and no ERR; BUSY stays 0.
- START re-asserted during a transfer -> ignored. A START on the first idle cycle after the transfer -> accepted with normal ACK_DELAY timing.
- CROBAR asserted between the 2nd and 3rd strobes of a 4-word write:
  - outputs 0 on the next cycle;
  - the first two words are written, the last two are not;
  - a fresh read afterwards works normally.
